// File: rtl/mux_n_1_scan.sv
// mux_n_1_scan
// N_CH-to-1 registered channel multiplexer with two operating modes:
//   manual - the channel named by S is registered onto Y every cycle
//   scan   - channels 0..N_CH-1 are visited in turn, DWELL cycles each,
//            with Y tracking the live data of the visited channel
//
// Optional feature: define MUX_PARITY_EN to add the Y_par output
// (registered XOR of Y, valid in the same cycle as Y).
//
// Ports
//   clk       single clock, all logic on the rising edge
//   rst       synchronous active-high reset
//   I         packed channel data, channel k is I[k*W +: W]
//   S         manual-mode channel select
//   mode      0 = manual, 1 = auto-scan
//   Y         registered selected channel data
//   Y_ch      channel index that produced the current Y
//   Y_stb     one-cycle pulse when Y_ch changes or a scan step starts
//   scan_wrap one-cycle pulse when the scan wraps from N_CH-1 to 0
//   sel_err   registered flag, manual select out of range
//   Y_par     (MUX_PARITY_EN only) registered parity of Y

module mux_n_1_scan #(
    parameter int N_CH  = 4,
    parameter int W     = 1,
    parameter int SEL_W = 2,
    parameter int DWELL = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH*W-1:0] I,
    input  logic [SEL_W-1:0]  S,
    input  logic              mode,
    output logic [W-1:0]      Y,
    output logic [SEL_W-1:0]  Y_ch,
    output logic              Y_stb,
    output logic              scan_wrap,
`ifdef MUX_PARITY_EN
    output logic              sel_err,
    output logic              Y_par
`else
    output logic              sel_err
`endif
);

    localparam int                N_SLOT     = 1 << SEL_W;
    localparam logic [SEL_W-1:0]  LAST_CH    = SEL_W'(N_CH - 1);
    localparam logic [7:0]        DWELL_LAST = 8'(DWELL - 1);

    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [7:0]       dwell_q;
    logic [7:0]       dwell_d;
    logic [SEL_W-1:0] ch_d;
    logic [W-1:0]     y_d;
    logic             stb_d;
    logic             wrap_d;
    logic             err_d;

    // The select space is padded out to 2**SEL_W slots; the unused slots
    // read as zero, which gives the out-of-range manual result for free.
    logic [W-1:0]     slot [N_SLOT];

    for (genvar k = 0; k < N_SLOT; k++) begin : g_slot
        if (k < N_CH) begin : g_used
            assign slot[k] = I[k*W +: W];
        end else begin : g_pad
            assign slot[k] = '0;
        end
    end

    // Next-state logic. Y_ch doubles as the scan channel counter, so the
    // scan position is simply the channel currently on the output.
    // Entering scan (registered state still MANUAL) restarts at channel 0.
    always_comb begin
        state_d = mode ? SCAN : MANUAL;
        ch_d    = Y_ch;
        dwell_d = '0;
        stb_d   = 1'b0;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        if (mode) begin
            if (state_q == MANUAL) begin
                ch_d  = '0;
                stb_d = 1'b1;
            end else if (dwell_q == DWELL_LAST) begin
                stb_d = 1'b1;
                if (Y_ch == LAST_CH) begin
                    ch_d   = '0;
                    wrap_d = 1'b1;
                end else begin
                    ch_d = Y_ch + 1'b1;
                end
            end else begin
                dwell_d = dwell_q + 8'd1;
            end
        end else begin
            ch_d  = S;
            stb_d = (S != Y_ch);
            err_d = (int'(S) >= N_CH);
        end
        y_d = slot[ch_d];
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= MANUAL;
            dwell_q   <= '0;
            Y         <= '0;
            Y_ch      <= '0;
            Y_stb     <= 1'b0;
            scan_wrap <= 1'b0;
            sel_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            dwell_q   <= dwell_d;
            Y         <= y_d;
            Y_ch      <= ch_d;
            Y_stb     <= stb_d;
            scan_wrap <= wrap_d;
            sel_err   <= err_d;
        end
    end

`ifdef MUX_PARITY_EN
    // Parity is taken from the next Y value so it lines up with Y.
    always_ff @(posedge clk) begin
        if (rst) begin
            Y_par <= 1'b0;
        end else begin
            Y_par <= ^y_d;
        end
    end
`endif

endmodule

// File: tb/tb_mux_n_1_scan.sv
// tb_mux_n_1_scan
// Drives two instances of mux_n_1_scan from shared control inputs:
//   dut  - N_CH=4, W=1, SEL_W=2, DWELL=4
//   dut3 - N_CH=3, W=4, SEL_W=2, DWELL=1 (out-of-range select, fast scan)
// Expected results are queued when stimulus is applied and popped when
// the registered outputs are sampled one cycle later.

module tb_mux_n_1_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [1:0]  s;
    logic [3:0]  i;
    logic [11:0] i3;

    logic        y;
    logic [1:0]  ych;
    logic        stb;
    logic        wrap;
    logic        err;
    logic [3:0]  y3;
    logic [1:0]  ych3;
    logic        stb3;
    logic        wrap3;
    logic        err3;
`ifdef MUX_PARITY_EN
    logic        par;
    logic        par3;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mux_n_1_scan #(.N_CH(4), .W(1), .SEL_W(2), .DWELL(4)) dut (
        .clk(clk), .rst(rst), .I(i), .S(s), .mode(mode),
        .Y(y), .Y_ch(ych), .Y_stb(stb), .scan_wrap(wrap),
`ifdef MUX_PARITY_EN
        .sel_err(err), .Y_par(par)
`else
        .sel_err(err)
`endif
    );

    mux_n_1_scan #(.N_CH(3), .W(4), .SEL_W(2), .DWELL(1)) dut3 (
        .clk(clk), .rst(rst), .I(i3), .S(s), .mode(mode),
        .Y(y3), .Y_ch(ych3), .Y_stb(stb3), .scan_wrap(wrap3),
`ifdef MUX_PARITY_EN
        .sel_err(err3), .Y_par(par3)
`else
        .sel_err(err3)
`endif
    );

    // chk3: 0 = dut3 unchecked, 1 = Y/sel_err only, 2 = all outputs
    typedef struct {
        int         tag;
        int         chk3;
        logic       y;
        logic [1:0] ch;
        logic       stb;
        logic       wrap;
        logic       err;
        logic [3:0] y3;
        logic [1:0] ch3;
        logic       stb3;
        logic       wrap3;
        logic       err3;
    } exp_t;

    typedef struct {
        logic       rst;
        logic       mode;
        logic [1:0] s;
        logic [3:0] i;
        logic       y;
        logic [1:0] ch;
        logic       stb;
        int         chk3;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[13];

    function automatic logic [3:0] ch3Val(input logic [1:0] sel);
        case (sel)
            2'd0:    return 4'h7;
            2'd1:    return 4'hA;
            2'd2:    return 4'hC;
            default: return 4'h0;
        endcase
    endfunction

    task automatic compareField(input string name, input int tag,
                                input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("[TB] FAIL %s step %0d: got %0h, expected %0h", name, tag, act, want);
        end
    endtask

    // Drive inputs at the falling edge and queue what the DUT must show
    // after the following rising edge.
    task automatic applyStimulus(input logic r, input logic m, input logic [1:0] sv,
                                 input logic [3:0] iv, input exp_t e);
        @(negedge clk);
        rst  = r;
        mode = m;
        s    = sv;
        i    = iv;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
        end else begin
            e = exp_q.pop_front();
            compareField("Y", e.tag, 32'(y), 32'(e.y));
            compareField("Y_ch", e.tag, 32'(ych), 32'(e.ch));
            compareField("Y_stb", e.tag, 32'(stb), 32'(e.stb));
            compareField("scan_wrap", e.tag, 32'(wrap), 32'(e.wrap));
            compareField("sel_err", e.tag, 32'(err), 32'(e.err));
`ifdef MUX_PARITY_EN
            compareField("Y_par", e.tag, 32'(par), 32'(e.y));
`endif
            if (e.chk3 >= 1) begin
                compareField("Y3", e.tag, 32'(y3), 32'(e.y3));
                compareField("sel_err3", e.tag, 32'(err3), 32'(e.err3));
`ifdef MUX_PARITY_EN
                compareField("Y_par3", e.tag, 32'(par3), 32'(^e.y3));
`endif
            end
            if (e.chk3 >= 2) begin
                compareField("Y_ch3", e.tag, 32'(ych3), 32'(e.ch3));
                compareField("Y_stb3", e.tag, 32'(stb3), 32'(e.stb3));
                compareField("scan_wrap3", e.tag, 32'(wrap3), 32'(e.wrap3));
            end
        end
    endtask

    // Scan run of n cycles starting from scan entry (k = 0). From step
    // alt_k onward the dut data is switched to show Y follows live I.
    task automatic scanSteps(input int n, input int alt_k, input int tag_base,
                             input logic [1:0] sv);
        exp_t       e;
        logic [3:0] ival;
        int         ch;
        int         c3;
        for (int k = 0; k < n; k++) begin
            ival    = (k >= alt_k) ? 4'b0100 : 4'b1010;
            ch      = (k / 4) % 4;
            c3      = k % 3;
            e.tag   = tag_base + k;
            e.chk3  = 2;
            e.ch    = 2'(ch);
            e.y     = ival[ch];
            e.stb   = (k % 4 == 0);
            e.wrap  = (k % 4 == 0) && (k > 0) && (ch == 0);
            e.err   = 1'b0;
            e.ch3   = 2'(c3);
            e.y3    = ch3Val(2'(c3));
            e.stb3  = 1'b1;
            e.wrap3 = (k > 0) && (c3 == 0);
            e.err3  = 1'b0;
            applyStimulus(1'b0, 1'b1, sv, ival, e);
            checkOutput();
        end
    endtask

    initial begin
        exp_t e;
        rst  = 1'b1;
        mode = 1'b0;
        s    = 2'd0;
        i    = 4'b1010;
        i3   = {4'hC, 4'hA, 4'h7};

        //          rst   mode  s      i        y     ch     stb   chk3
        vecs[0]  = '{1'b1, 1'b0, 2'd0, 4'b1010, 1'b0, 2'd0, 1'b0, 2};
        vecs[1]  = '{1'b1, 1'b0, 2'd2, 4'b1010, 1'b0, 2'd0, 1'b0, 2};
        vecs[2]  = '{1'b0, 1'b0, 2'd0, 4'b1010, 1'b0, 2'd0, 1'b0, 1};
        vecs[3]  = '{1'b0, 1'b0, 2'd0, 4'b1010, 1'b0, 2'd0, 1'b0, 1};
        vecs[4]  = '{1'b0, 1'b0, 2'd1, 4'b1010, 1'b1, 2'd1, 1'b1, 1};
        vecs[5]  = '{1'b0, 1'b0, 2'd1, 4'b1010, 1'b1, 2'd1, 1'b0, 1};
        vecs[6]  = '{1'b0, 1'b0, 2'd2, 4'b1010, 1'b0, 2'd2, 1'b1, 1};
        vecs[7]  = '{1'b0, 1'b0, 2'd2, 4'b1010, 1'b0, 2'd2, 1'b0, 1};
        vecs[8]  = '{1'b0, 1'b0, 2'd3, 4'b1010, 1'b1, 2'd3, 1'b1, 1};
        vecs[9]  = '{1'b0, 1'b0, 2'd3, 4'b1010, 1'b1, 2'd3, 1'b0, 1};
        vecs[10] = '{1'b0, 1'b0, 2'd3, 4'b0101, 1'b0, 2'd3, 1'b0, 1};
        vecs[11] = '{1'b0, 1'b0, 2'd0, 4'b0101, 1'b1, 2'd0, 1'b1, 1};
        vecs[12] = '{1'b0, 1'b0, 2'd1, 4'b1010, 1'b1, 2'd1, 1'b1, 1};

        $display("[TB] manual-mode table");
        for (int n = 0; n < 13; n++) begin
            e.tag   = n;
            e.chk3  = vecs[n].chk3;
            e.y     = vecs[n].y;
            e.ch    = vecs[n].ch;
            e.stb   = vecs[n].stb;
            e.wrap  = 1'b0;
            e.err   = 1'b0;
            e.y3    = vecs[n].rst ? 4'h0 : ch3Val(vecs[n].s);
            e.err3  = !vecs[n].rst && (vecs[n].s == 2'd3);
            e.ch3   = 2'd0;
            e.stb3  = 1'b0;
            e.wrap3 = 1'b0;
            applyStimulus(vecs[n].rst, vecs[n].mode, vecs[n].s, vecs[n].i, e);
            checkOutput();
        end

        $display("[TB] scan from manual, S ignored, wrap at step 16");
        scanSteps(22, 10, 100, 2'd3);

        $display("[TB] scan -> manual mid-dwell with S=3");
        e = '{tag: 150, chk3: 1, y: 1'b1, ch: 2'd3, stb: 1'b1, wrap: 1'b0, err: 1'b0,
              y3: 4'h0, ch3: 2'd0, stb3: 1'b0, wrap3: 1'b0, err3: 1'b1};
        applyStimulus(1'b0, 1'b0, 2'd3, 4'b1000, e);
        checkOutput();

        $display("[TB] reset mid-scan then restart");
        scanSteps(10, 1000, 200, 2'd0);
        e = '{tag: 250, chk3: 2, y: 1'b0, ch: 2'd0, stb: 1'b0, wrap: 1'b0, err: 1'b0,
              y3: 4'h0, ch3: 2'd0, stb3: 1'b0, wrap3: 1'b0, err3: 1'b0};
        applyStimulus(1'b1, 1'b1, 2'd0, 4'b1010, e);
        checkOutput();
        scanSteps(6, 1000, 300, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mux_n_1_scan.md
MUX_N_1_SCAN -- requirements
Module: mux_n_1_scan

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of input channels (2..16).
REQ-002 SHALL have parameter W, default 1: bits per channel (1..32).
REQ-003 SHALL have parameter SEL_W, default 2: select width; 2**SEL_W >= N_CH.
REQ-004 SHALL have parameter DWELL, default 4: cycles spent on each channel in scan mode (1..255).
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port I  input  N_CH*W  packed channel data; channel k is I[k*W +: W].
REQ-008 SHALL have port S  input  SEL_W  manual-mode channel select.
REQ-009 SHALL have port mode  input  1  0 = manual, 1 = auto-scan.
REQ-010 SHALL have port Y  output  W  registered selected channel data.
REQ-011 SHALL have port Y_ch  output  SEL_W  channel index that produced the current Y.
REQ-012 SHALL have port Y_stb  output  1  one-cycle pulse when Y_ch changes or a new sample is taken.
REQ-013 SHALL have port scan_wrap  output  1  one-cycle pulse when scan wraps from N_CH-1 to 0.
REQ-014 SHALL have port sel_err  output  1  registered flag: manual select out of range.

Function
REQ-015 SHALL implement states MANUAL and SCAN; state = SCAN while mode=1, else MANUAL, updated each cycle.
REQ-016 MANUAL: Y <= channel S, Y_ch <= S; latency one cycle from S/I change to Y.
REQ-017 MANUAL: Y_stb SHALL pulse on the cycle Y_ch takes a value different from its previous value.
REQ-018 MANUAL: S >= N_CH SHALL give Y <= 0, Y_ch <= S, sel_err <= 1; sel_err <= 0 for in-range S.
REQ-019 MANUAL->SCAN (mode 0->1): first SCAN cycle SHALL load channel 0, clear dwell counter, pulse Y_stb.
REQ-020 SCAN: Y SHALL track the live I of the current channel every cycle (one-cycle latency).
REQ-021 SCAN: dwell counter counts 0..DWELL-1; on DWELL-1 channel advances by 1 and Y_stb pulses with the new channel.
REQ-022 SCAN: advance from N_CH-1 SHALL wrap to 0 and pulse scan_wrap in the same cycle as Y_stb.
REQ-023 SCAN: S SHALL be ignored, sel_err held 0.
REQ-024 SCAN->MANUAL mid-dwell: next cycle SHALL be MANUAL per REQ-016; dwell and scan counters cleared.
REQ-025 DWELL=1: channel SHALL advance every cycle, Y_stb high every cycle in SCAN.
REQ-026 N_CH=2**SEL_W: sel_err SHALL never assert.

Reset
REQ-027 rst=1 SHALL force Y=0, Y_ch=0, Y_stb=0, scan_wrap=0, sel_err=0, state MANUAL, counters 0 on the next edge.
REQ-028 Reset mid-scan SHALL abandon the scan; after release, mode=1 restarts from channel 0 per REQ-019.
REQ-029 First cycle after reset release SHALL not pulse Y_stb unless Y_ch changes from 0.

Configuration
REQ-030 Macro MUX_PARITY_EN defined: extra output Y_par (1 bit) SHALL equal registered even parity (XOR) of Y, same cycle as Y, reset 0.
REQ-031 Macro MUX_PARITY_EN undefined: Y_par port SHALL not exist; all other behaviour identical.

Verification (N_CH=4, W=1, SEL_W=2, DWELL=4 unless stated)
REQ-032 I=4'b1010, mode=0, S=00,01,10,11 each 10 cycles -> Y=0,1,0,1 one cycle after each S change, Y_stb one pulse per change.
REQ-033 I=4'b1010, mode 0->1 -> Y_ch 0,1,2,3 each 4 cycles, Y 0,1,0,1, scan_wrap pulse on 3->0 at cycle 16.
REQ-034 N_CH=3, mode=0, S=11 -> Y=0, sel_err=1 next cycle; S=01 -> sel_err=0.
REQ-035 Scan at Y_ch=2 dwell 1, assert rst one cycle -> all outputs 0; release with mode=1 -> restart at channel 0 with Y_stb.
REQ-036 Scan at Y_ch=1, mode 1->0 with S=11 -> next cycle Y=I[3], Y_ch=3, Y_stb=1.
REQ-037 MUX_PARITY_EN, W=4, I channel 0=4'b0111, S=00 -> Y=0111, Y_par=1 one cycle later.
